vector_ram_loader: RTL

Write-side front end for `vector_ram`: accepts a valid/ready stream of 32-bit words, packs 32 consecutive words into one 1024-bit line and writes each line into `vector_ram` through its `write_enable`/`addr`/`in` port. One `start` command loads a run of consecutive lines from a base address. Sits between the host/DMA input stream and the dense-vector RAM of the sparse accelerator, ahead of the compute engine that later reads the vector.

---
 rtl/sparse_pkg.sv | 16 +
 rtl/line_packer.sv | 46 ++++
 rtl/vector_ram_loader.sv | 132 +++++++++++++
 3 files changed

// File: rtl/sparse_pkg.sv
// Shared constants and state type for the sparse accelerator's dense-vector RAM path.
package sparse_pkg;
  localparam int WORD_W         = 32;
  localparam int LINE_W         = 1024;
  localparam int ADDR_W         = 7;
  localparam int WORDS_PER_LINE = LINE_W / WORD_W;
  localparam int WIDX_W         = $clog2(WORDS_PER_LINE);
  localparam int LCNT_W         = ADDR_W + 1;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_FILL  = 2'd1,
    S_WRITE = 2'd2,
    S_DONE  = 2'd3
  } state_e;
endpackage

// File: rtl/line_packer.sv
// Packs consecutive stream words into one RAM line, word 0 in the LSBs.
module line_packer
  import sparse_pkg::*;
(
  input  logic              clk,
  input  logic              rst_n,
  input  logic              clear,
  input  logic              fill_en,
  input  logic              in_valid,
  input  logic [WORD_W-1:0] in_data,
  output logic              word_valid,
  output logic              line_full,
  output logic [LINE_W-1:0] line
);
  logic [WIDX_W-1:0] idx_q, idx_d;
  logic [LINE_W-1:0] buf_q, buf_d;

  assign word_valid = fill_en & in_valid;
  assign line_full  = word_valid && (idx_q == WIDX_W'(WORDS_PER_LINE - 1));
  assign line       = buf_q;

  // Clearing on entry to a new line is what makes unfilled positions read as zero.
  always_comb begin
    idx_d = idx_q;
    buf_d = buf_q;
    if (clear) begin
      idx_d = '0;
      buf_d = '0;
    end else if (word_valid) begin
      for (int k = 0; k < WORDS_PER_LINE; k++) begin
        if (idx_q == WIDX_W'(k)) buf_d[k*WORD_W +: WORD_W] = in_data;
      end
      idx_d = idx_q + WIDX_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      idx_q <= '0;
      buf_q <= '0;
    end else begin
      idx_q <= idx_d;
      buf_q <= buf_d;
    end
  end
endmodule

// File: rtl/vector_ram_loader.sv
// Stream-to-line loader for vector_ram. Define VECTOR_LOADER_ZERO_PAD_EN to zero-pad
// and write a line cut short by s_last; otherwise such a partial line is dropped with err.
module vector_ram_loader
  import sparse_pkg::*;
(
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic [ADDR_W-1:0] base_addr,
  input  logic [ADDR_W:0]   num_lines,
  input  logic              s_valid,
  input  logic [WORD_W-1:0] s_data,
  input  logic              s_last,
  output logic              s_ready,
  output logic              ram_we,
  output logic [ADDR_W-1:0] ram_addr,
  output logic [LINE_W-1:0] ram_in,
  output logic              busy,
  output logic              done,
  output logic              err,
  output logic [ADDR_W:0]   lines_written,
  output state_e            state_dbg
);
  // Stream handshake: a word moves when s_valid && s_ready on a rising edge;
  // s_ready is high exactly in FILL, s_data/s_last are don't-care otherwise.
  localparam logic [LCNT_W-1:0] MAX_LINES = LCNT_W'(2 ** ADDR_W);
  localparam logic [LCNT_W-1:0] ONE       = LCNT_W'(1);

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] base_q, base_d;
  logic [LCNT_W-1:0] num_q, num_d, line_q, line_d, lw_q, lw_d;
  logic              err_q, err_d, last_q, last_d;
  logic              clear, word_valid, line_full;

  line_packer u_packer (
    .clk        (clk),
    .rst_n      (rst_n),
    .clear      (clear),
    .fill_en    (state_q == S_FILL),
    .in_valid   (s_valid),
    .in_data    (s_data),
    .word_valid (word_valid),
    .line_full  (line_full),
    .line       (ram_in)
  );

  always_comb begin
    state_d = state_q;
    base_d  = base_q;
    num_d   = num_q;
    line_d  = line_q;
    lw_d    = lw_q;
    err_d   = err_q;
    last_d  = last_q;
    clear   = 1'b0;
    case (state_q)
      S_IDLE: if (start) begin
        base_d = base_addr;
        num_d  = num_lines;
        line_d = '0;
        lw_d   = '0;
        err_d  = 1'b0;
        last_d = 1'b0;
        if (num_lines == '0) begin
          state_d = S_DONE;
        end else if (num_lines > MAX_LINES) begin
          err_d   = 1'b1;
          state_d = S_DONE;
        end else begin
          clear   = 1'b1;
          state_d = S_FILL;
        end
      end
      S_FILL: if (word_valid) begin
        if (line_full) begin
          last_d  = s_last;
          state_d = S_WRITE;
        end else if (s_last) begin
`ifdef VECTOR_LOADER_ZERO_PAD_EN
          last_d  = 1'b1;
          state_d = S_WRITE;
`else
          err_d   = 1'b1;
          state_d = S_DONE;
`endif
        end
      end
      S_WRITE: begin
        lw_d = lw_q + ONE;
        // s_last on a line boundary ends the run early without error.
        if (last_q || (line_q + ONE == num_q)) begin
          state_d = S_DONE;
        end else begin
          line_d  = line_q + ONE;
          clear   = 1'b1;
          state_d = S_FILL;
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      base_q  <= '0;
      num_q   <= '0;
      line_q  <= '0;
      lw_q    <= '0;
      err_q   <= 1'b0;
      last_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      base_q  <= base_d;
      num_q   <= num_d;
      line_q  <= line_d;
      lw_q    <= lw_d;
      err_q   <= err_d;
      last_q  <= last_d;
    end
  end

  assign s_ready       = (state_q == S_FILL);
  assign ram_we        = (state_q == S_WRITE);
  assign ram_addr      = base_q + line_q[ADDR_W-1:0];
  assign busy          = (state_q != S_IDLE);
  assign done          = (state_q == S_DONE);
  assign err           = err_q;
  assign lines_written = lw_q;
  assign state_dbg     = state_q;
endmodule
